// File: rtl/rx_pkg.sv
// Shared definitions for the receive-side frame-buffer writer: FSM state
// encoding, default geometry, segment count and watchdog length.
package rx_pkg;

    localparam int unsigned SEGMENT_NUMBER_MAX_DEF = 5;
    localparam int unsigned BYTES_PER_SEGMENT_DEF  = 1200;
    localparam int unsigned SEG_COUNT              = SEGMENT_NUMBER_MAX_DEF + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WRITE,
        ST_DISCARD,
        ST_COMMIT
    } state_t;

    // A packet that has not seen eop after two segments' worth of cycles is abandoned.
    function automatic int unsigned wdog_len(input int unsigned bytes_per_segment);
        return 2 * bytes_per_segment;
    endfunction

    localparam int unsigned WDOG_CYCLES = wdog_len(BYTES_PER_SEGMENT_DEF);

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/rx_memory_control_if.sv
// Payload stream with packet header fields, as delivered by the frame validator.
interface rx_memory_control_if;

    logic        sop;
    logic [15:0] segment_num;
    logic [7:0]  txid;
    logic [7:0]  aux;
    logic [7:0]  data;
    logic        data_valid;
    logic        eop;
    logic        crc_ok;

    modport master (
        output sop, segment_num, txid, aux, data, data_valid, eop, crc_ok
    );

    modport slave (
        input sop, segment_num, txid, aux, data, data_valid, eop, crc_ok
    );

endinterface

// File: rtl/rx_segment_bitmap.sv
// Per-frame segment coverage vector: test/set by index, bulk clear and a
// registered full flag. 'completes' tells whether setting 'index' now would
// fill the vector, so the caller can act in the same cycle as the set.
module rx_segment_bitmap
    import rx_pkg::*;
#(
    parameter int unsigned NUM_SEGMENTS = SEG_COUNT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set,
    input  logic        clear,
    input  logic [15:0] index,
    output logic        hit,
    output logic        completes,
    output logic        full
);

    logic [NUM_SEGMENTS-1:0] bits;
    logic [NUM_SEGMENTS-1:0] mask;

    // One-hot decode of the index; out-of-range indices decode to no bit.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NUM_SEGMENTS; i++) begin
            if (index == 16'(i)) mask[i] = 1'b1;
        end
    end

    assign hit       = |(bits & mask);
    assign completes = &(bits | mask);

    // Coverage storage; clear has priority over set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits <= '0;
            full <= 1'b0;
        end else if (clear) begin
            bits <= '0;
            full <= 1'b0;
        end else if (set) begin
            bits <= bits | mask;
            full <= &(bits | mask);
        end
    end

endmodule

// File: rtl/rx_memory_control.sv
// Receive-side frame-buffer writer: places each validated segment payload at
// segment_num*BYTES_PER_SEGMENT, drops redundant copies, tracks frame coverage.
// Optional statistics counters are built when RX_MEMCTRL_STATS_EN is defined.
module rx_memory_control
    import rx_pkg::*;
#(
    parameter int unsigned SEGMENT_NUMBER_MAX = SEGMENT_NUMBER_MAX_DEF,
    parameter int unsigned BYTES_PER_SEGMENT  = BYTES_PER_SEGMENT_DEF,
    parameter int unsigned ADDR_WIDTH         = 24
) (
    input  logic                  clk125MHz,
    input  logic                  rst_n,
    rx_memory_control_if.slave    rx,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [7:0]            dina,
    output logic                  frame_done,
    output logic                  frame_incomplete,
    output logic                  busy
`ifdef RX_MEMCTRL_STATS_EN
    ,
    output logic [15:0]           dup_count,
    output logic [15:0]           crc_err_count,
    output logic [15:0]           drop_count
`endif
);

    localparam int unsigned WDOG_LEN = wdog_len(BYTES_PER_SEGMENT);

    state_t                state;
    logic [15:0]           seg;
    logic                  par;
    logic                  cur_parity;
    logic [15:0]           offset;
    logic                  overflow;
    logic                  crc_lat;
    logic [31:0]           wdog;
    logic [ADDR_WIDTH-1:0] base;

    logic bm_hit, bm_completes, bm_full, bm_set, bm_clear;
    logic par_change, in_range, reject, commit_ok, wdog_abort;

    logic unused_hdr;
    assign unused_hdr = ^{rx.txid, rx.aux[7:1]};

    // seg is latched at sop, so the product is stable for the whole packet;
    // keeping it combinational lets the byte right after sop be written in CHECK.
    assign base = ADDR_WIDTH'(seg) * ADDR_WIDTH'(BYTES_PER_SEGMENT);

    // Per-cycle decisions shared by the FSM, the bitmap and the counters.
    always_comb begin
        par_change = (state == ST_CHECK) && (par != cur_parity);
        in_range   = (seg <= 16'(SEGMENT_NUMBER_MAX));
        reject     = !in_range || (!par_change && bm_hit);
        commit_ok  = (state == ST_COMMIT) && crc_lat && !overflow &&
                     (offset == 16'(BYTES_PER_SEGMENT));
        wdog_abort = ((state == ST_WRITE) || (state == ST_DISCARD)) && !rx.eop &&
                     (wdog == 32'(WDOG_LEN - 1));
        bm_set     = commit_ok;
        bm_clear   = par_change || (commit_ok && bm_completes);
    end

    rx_segment_bitmap #(
        .NUM_SEGMENTS (SEGMENT_NUMBER_MAX + 1)
    ) u_bitmap (
        .clk       (clk125MHz),
        .rst_n     (rst_n),
        .set       (bm_set),
        .clear     (bm_clear),
        .index     (seg),
        .hit       (bm_hit),
        .completes (bm_completes),
        .full      (bm_full)
    );

    // Packet FSM with registered BRAM port and status outputs.
    always_ff @(posedge clk125MHz or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            seg              <= '0;
            par              <= 1'b0;
            cur_parity       <= 1'b0;
            offset           <= '0;
            overflow         <= 1'b0;
            crc_lat          <= 1'b0;
            wdog             <= '0;
            wea              <= 1'b0;
            addra            <= '0;
            dina             <= '0;
            frame_done       <= 1'b0;
            frame_incomplete <= 1'b0;
            busy             <= 1'b0;
        end else begin
            wea              <= 1'b0;
            frame_done       <= 1'b0;
            frame_incomplete <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx.sop) begin
                        seg      <= rx.segment_num;
                        par      <= rx.aux[0];
                        offset   <= '0;
                        overflow <= 1'b0;
                        wdog     <= '0;
                        busy     <= 1'b1;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    wdog <= wdog + 32'd1;
                    if (par_change) begin
                        if (bm_full) frame_done <= 1'b1;
                        else         frame_incomplete <= 1'b1;
                        cur_parity <= par;
                    end
                    if (reject) begin
                        state <= ST_DISCARD;
                    end else begin
                        state <= ST_WRITE;
                        if (rx.data_valid) begin
                            wea    <= 1'b1;
                            addra  <= base;
                            dina   <= rx.data;
                            offset <= 16'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    wdog <= wdog + 32'd1;
                    if (rx.data_valid) begin
                        if (offset < 16'(BYTES_PER_SEGMENT)) begin
                            wea    <= 1'b1;
                            addra  <= base + ADDR_WIDTH'(offset);
                            dina   <= rx.data;
                            offset <= offset + 16'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    if (rx.eop) begin
                        crc_lat <= rx.crc_ok;
                        state   <= ST_COMMIT;
                    end else if (wdog_abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    wdog <= wdog + 32'd1;
                    if (rx.eop || wdog_abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    if (commit_ok && bm_completes) frame_done <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RX_MEMCTRL_STATS_EN
    // Saturating event counters: duplicates, bad CRCs, and dropped packets.
    always_ff @(posedge clk125MHz or negedge rst_n) begin
        if (!rst_n) begin
            dup_count     <= '0;
            crc_err_count <= '0;
            drop_count    <= '0;
        end else begin
            if (state == ST_CHECK && in_range && reject)
                dup_count <= sat_inc(dup_count);
            if (state == ST_COMMIT && !crc_lat)
                crc_err_count <= sat_inc(crc_err_count);
            if ((state == ST_CHECK && !in_range) ||
                (state == ST_COMMIT && overflow) || wdog_abort)
                drop_count <= sat_inc(drop_count);
        end
    end
`endif

endmodule

// File: tb/tb_rx_memory_control.sv
// Scoreboard bench for rx_memory_control: expected BRAM writes are queued as
// bytes are driven and popped as the DUT writes; frame pulses are counted
// against a small coverage model.
module tb_rx_memory_control;
    import rx_pkg::*;

    localparam int unsigned BPS     = 1200;
    localparam int unsigned SEG_MAX = 5;

    typedef struct packed {
        logic [23:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    rx_memory_control_if rx();

    logic        wea;
    logic [23:0] addra;
    logic [7:0]  dina;
    logic        frame_done, frame_incomplete, busy;
`ifdef RX_MEMCTRL_STATS_EN
    logic [15:0] dup_count, crc_err_count, drop_count;
`endif

    rx_memory_control #(
        .SEGMENT_NUMBER_MAX (SEG_MAX),
        .BYTES_PER_SEGMENT  (BPS),
        .ADDR_WIDTH         (24)
    ) dut (
        .clk125MHz        (clk),
        .rst_n            (rst_n),
        .rx               (rx),
        .wea              (wea),
        .addra            (addra),
        .dina             (dina),
        .frame_done       (frame_done),
        .frame_incomplete (frame_incomplete),
        .busy             (busy)
`ifdef RX_MEMCTRL_STATS_EN
        ,
        .dup_count        (dup_count),
        .crc_err_count    (crc_err_count),
        .drop_count       (drop_count)
`endif
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    wr_t         exp_q[$];
    wr_t         exp_e;
    int unsigned fd_seen = 0, fi_seen = 0;
    int unsigned exp_fd  = 0, exp_fi  = 0;
    bit [5:0]    model_bm;
    bit          model_par;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done)       fd_seen++;
            if (frame_incomplete) fi_seen++;
            if (wea) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(addra), 32'hFFFFFFFF);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wr_addr", 32'(addra), 32'(exp_e.addr));
                    check("wr_data", 32'(dina), 32'(exp_e.data));
                end
            end
        end
    end

    task automatic idle_inputs();
        rx.sop = 1'b0; rx.segment_num = '0; rx.txid = '0; rx.aux = '0;
        rx.data = '0; rx.data_valid = 1'b0; rx.eop = 1'b0; rx.crc_ok = 1'b0;
    endtask

    task automatic model_reset();
        model_bm  = '0;
        model_par = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic model_sop(input int unsigned seg, input bit par, output bit accept);
        if (par != model_par) begin
            if (&model_bm) exp_fd++;
            else           exp_fi++;
            model_bm  = '0;
            model_par = par;
        end
        accept = (seg <= SEG_MAX) && !model_bm[seg % 6];
    endtask

    task automatic checkpoint(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_q_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_frame_done"}, 32'(fd_seen), 32'(exp_fd));
        check({tag, "_frame_inc"}, 32'(fi_seen), 32'(exp_fi));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // eop_mode: 0 = eop after last byte, 1 = eop with last byte, 2 = no eop (watchdog).
    task automatic send_pkt(input int unsigned seg, input int unsigned tx, input bit par,
                            input int unsigned nbytes, input bit crc,
                            input int unsigned eop_mode, input bit stray_sop);
        bit         accept;
        logic [7:0] b;
        model_sop(seg, par, accept);
        @(negedge clk);
        rx.sop = 1'b1; rx.segment_num = 16'(seg); rx.txid = 8'(tx); rx.aux = {7'd0, par};
        for (int unsigned i = 0; i < nbytes; i++) begin
            @(negedge clk);
            rx.sop = 1'b0;
            if (i == 20) begin
                rx.data_valid = 1'b0;
                rx.sop = stray_sop; rx.segment_num = 16'd0; rx.aux = {7'd0, ~par};
                @(negedge clk);
                rx.sop = 1'b0;
            end
            b = 8'($urandom);
            rx.data = b; rx.data_valid = 1'b1;
            if (accept && i < BPS) exp_q.push_back('{addr: 24'(seg * BPS + i), data: b});
            if (eop_mode == 1 && i == nbytes - 1) begin
                rx.eop = 1'b1; rx.crc_ok = crc;
            end
        end
        @(negedge clk);
        rx.data_valid = 1'b0; rx.eop = 1'b0; rx.crc_ok = 1'b0;
        if (eop_mode == 0) begin
            rx.eop = 1'b1; rx.crc_ok = crc;
            @(negedge clk);
            rx.eop = 1'b0; rx.crc_ok = 1'b0;
        end
        if (eop_mode == 2) begin
            repeat (100) @(negedge clk);
            check("wdog_busy_held", 32'(busy), 32'd1);
            repeat (WDOG_CYCLES) @(negedge clk);
        end else if (accept && crc && nbytes == BPS) begin
            model_bm[seg] = 1'b1;
            if (&model_bm) begin
                exp_fd++;
                model_bm = '0;
            end
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_wea", 32'(wea), 32'd0);
        check("rst_addra", 32'(addra), 32'd0);
        check("rst_dina", 32'(dina), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_inc", 32'(frame_incomplete), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full frame, one copy per segment.
        for (int unsigned s = 0; s <= SEG_MAX; s++) begin
            send_pkt(s, 0, 1'b0, BPS, 1'b1, s % 2, 1'b0);
            checkpoint("frame");
        end

        // Redundant copies of segment 2.
        do_reset();
        for (int unsigned t = 0; t < 3; t++) begin
            send_pkt(2, t, 1'b0, BPS, 1'b1, 0, 1'b0);
            checkpoint("dup");
        end
`ifdef RX_MEMCTRL_STATS_EN
        check("dup_count", 32'(dup_count), 32'd2);
`endif

        // Bad CRC then good copy, then the rest of the frame.
        do_reset();
        send_pkt(3, 0, 1'b0, BPS, 1'b0, 1, 1'b0);
        checkpoint("crc_bad");
        send_pkt(3, 1, 1'b0, BPS, 1'b1, 0, 1'b0);
        checkpoint("crc_good");
        send_pkt(0, 0, 1'b0, BPS, 1'b1, 0, 1'b0);
        send_pkt(1, 0, 1'b0, BPS, 1'b1, 0, 1'b0);
        send_pkt(2, 0, 1'b0, BPS, 1'b1, 0, 1'b0);
        send_pkt(4, 0, 1'b0, BPS, 1'b1, 0, 1'b0);
        checkpoint("crc_rest");
        send_pkt(5, 0, 1'b0, BPS, 1'b1, 1, 1'b0);
        checkpoint("crc_frame");
        check("crc_frame_total", 32'(fd_seen), 32'd2);

        // Parity change before coverage is complete.
        do_reset();
        for (int unsigned s = 0; s < SEG_MAX; s++) send_pkt(s, 0, 1'b0, BPS, 1'b1, 0, 1'b0);
        checkpoint("inc_pre");
        send_pkt(0, 0, 1'b1, BPS, 1'b1, 0, 1'b0);
        checkpoint("inc_post");
        check("inc_total", 32'(fi_seen), 32'd1);

        // Out-of-range segment, oversized and undersized payloads, stray sop.
        do_reset();
        send_pkt(6, 0, 1'b0, 40, 1'b1, 0, 1'b0);
        checkpoint("range");
        send_pkt(1, 0, 1'b0, 1300, 1'b1, 0, 1'b1);
        checkpoint("oversize");
`ifdef RX_MEMCTRL_STATS_EN
        check("drop_count", 32'(drop_count), 32'd2);
`endif
        send_pkt(1, 1, 1'b0, BPS, 1'b1, 0, 1'b1);
        checkpoint("oversize_retry");
        send_pkt(4, 0, 1'b0, BPS - 1, 1'b1, 0, 1'b0);
        send_pkt(4, 1, 1'b0, BPS, 1'b1, 0, 1'b0);
        checkpoint("short_retry");

        // Watchdog abort, then the same segment is accepted again.
        do_reset();
        send_pkt(3, 0, 1'b0, 50, 1'b1, 2, 1'b0);
        checkpoint("wdog");
        send_pkt(3, 1, 1'b0, BPS, 1'b1, 0, 1'b0);
        checkpoint("wdog_retry");

        // Reset pulse in the middle of a write burst.
        do_reset();
        @(negedge clk);
        rx.sop = 1'b1; rx.segment_num = 16'd2; rx.aux = '0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            rx.sop = 1'b0;
            rx.data = 8'($urandom); rx.data_valid = 1'b1;
            exp_q.push_back('{addr: 24'(2 * BPS + i), data: rx.data});
        end
        @(negedge clk);
        check("midrst_wea_before", 32'(wea), 32'd1);
        #1;
        rst_n = 1'b0;
        rx.data_valid = 1'b0;
        #1;
        check("midrst_wea", 32'(wea), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addra", 32'(addra), 32'd0);
        check("midrst_q", 32'(exp_q.size()), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_pkt(0, 0, 1'b0, BPS, 1'b1, 0, 1'b0);
        checkpoint("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
